apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master.sv | 154 +++++++++++++++
 tb/tb_apb_master.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default widths for the APB requester.
// Imported by apb_master; no logic lives here.
package apb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// apb_master: one-transfer-at-a-time APB requester, all outputs registered.
// Optional ACCESS wait-state watchdog: define APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = apb_pkg::ADDR_W,
  parameter int DATA_W         = apb_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be 1..255");
  end

  apb_state_e state_q, state_d;

  logic              psel_d;
  logic              penable_d;
  logic              pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic              rsp_valid_d;
  logic              rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              abort;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_q, wait_d;
  logic       rsp_to_q;

  // Counts ACCESS cycles that saw PREADY low; restarts with each command.
  always_comb begin
    wait_d = wait_q;
    if (state_q == ST_IDLE && cmd_valid) begin
      wait_d = '0;
    end else if (state_q == ST_ACCESS && !PREADY) begin
      wait_d = wait_q + 8'd1;
    end
  end

  assign abort = (state_q == ST_ACCESS) && !PREADY
              && (wait_d == TO_LIMIT);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_q   <= '0;
      rsp_to_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      rsp_to_q <= abort;
    end
  end

  assign rsp_timeout = rsp_to_q;
`else
  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = PSELx;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY || abort) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          // abort only fires with PREADY low, so it always reports error
          rsp_err_d   = PREADY ? PSLVERR : 1'b1;
          if (PREADY && !PWRITE) begin
            rsp_rdata_d = PRDATA;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      cmd_ready <= 1'b1;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= (state_d == ST_IDLE);
      PSELx     <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed vector table, hand sequences for back-to-back
// and mid-transfer reset, then random traffic against a timeline model.
`timescale 1ns/1ps
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, PADDR;
  logic [DW-1:0] cmd_wdata, PWDATA, PRDATA, rsp_rdata;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic          PSELx, PENABLE, PWRITE, PREADY, PSLVERR;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic check(input string name,
                       input logic [95:0] got,
                       input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    int          e_lat;
    int          e_psel;
    int          e_pen;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
  } vec_t;

  vec_t vecs[7];

  task automatic run_txn(input vec_t v, input int idx);
    int cyc, npsel, npen;
    bit seen;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge PCLK);
    check({t, " cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    cyc = 0; npsel = 0; npen = 0; seen = 0;
    while (cyc < 100 && !seen) begin
      @(negedge PCLK);
      cyc++;
      cmd_valid = 1'b0;
      if (rsp_valid) begin
        seen = 1;
        check({t, " latency"}, cyc, v.e_lat);
        check({t, " psel cycles"}, npsel, v.e_psel);
        check({t, " penable cycles"}, npen, v.e_pen);
        check({t, " rdata"}, rsp_rdata, v.e_rdata);
        check({t, " err/to"}, {rsp_err, rsp_timeout},
              {v.e_err, v.e_to});
        check({t, " psel/pen in rsp"}, {PSELx, PENABLE}, 0);
        check({t, " addr hold"}, PADDR, v.addr);
        PREADY = 1'b0; PSLVERR = 1'b0;
      end else begin
        if (PSELx) begin
          npsel++;
          check({t, " bus stable"}, {PWRITE, PADDR, PWDATA},
                {v.wr, v.addr, v.wdata});
        end
        if (PENABLE) npen++;
        PREADY  = PENABLE && (npen == v.waits + 1);
        PSLVERR = PREADY ? v.slverr : 1'b1;
        PRDATA  = PREADY ? v.prdata : (32'hBAD0_0000 ^ npen);
      end
    end
    check({t, " response seen"}, seen, 1);
  endtask

  // random-phase model variables
  bit          busy, tto, twr, terr, rst_i, cv;
  int          rel, acc, w;
  logic [31:0] trd, la, ld, e_rd;
  logic        lw, e_rdy, e_psel, e_pen, e_rv, e_err, e_to;
  int          cnt, got;

  initial begin
    vecs[0] = '{1, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h1234_5678,
                3, 2, 1, 32'h0, 0, 0};
    vecs[1] = '{0, 32'h10, 32'h0, 3, 0, 32'hDEAD_BEEF,
                6, 5, 4, 32'hDEAD_BEEF, 0, 0};
    vecs[2] = '{0, 32'h1000, 32'h0, 0, 1, 32'h0000_CAFE,
                3, 2, 1, 32'h0000_CAFE, 1, 0};
    vecs[3] = '{1, 32'hFFFF_FFFC, 32'h5555_AAAA, 2, 1, 32'h7777_7777,
                5, 4, 3, 32'h0, 1, 0};
    vecs[4] = '{0, 32'h20, 32'h0, 15, 0, 32'h0BAD_F00D,
                18, 17, 16, 32'h0BAD_F00D, 0, 0};
`ifdef APB_MASTER_TIMEOUT_EN
    vecs[5] = '{0, 32'h30, 32'h0, 255, 0, 32'h0000_600D,
                18, 17, 16, 32'h0, 1, 1};
    vecs[6] = '{1, 32'h40, 32'h1111_2222, 16, 0, 32'h0,
                18, 17, 16, 32'h0, 1, 1};
`else
    vecs[5] = '{0, 32'h30, 32'h0, 40, 0, 32'h0000_600D,
                43, 42, 41, 32'h0000_600D, 0, 0};
    vecs[6] = '{1, 32'h40, 32'h1111_2222, 16, 0, 32'h0,
                19, 18, 17, 32'h0, 0, 0};
`endif

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    check("reset ctl",
          {PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}, 0);
    check("reset bus", {PADDR, PWDATA, rsp_rdata}, 0);
    PRESET = 1'b0;
    @(negedge PCLK);
    check("ready after reset", cmd_ready, 1);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // back-to-back: second command waits, accepted in rsp cycle
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'hA0; cmd_wdata = 32'hAAAA_0001;
    @(negedge PCLK);
    cmd_write = 1'b0; cmd_addr = 32'hB0; cmd_wdata = 32'h0;
    cnt = 1; got = 0;
    while (cnt < 20 && got == 0) begin
      if (rsp_valid) begin
        got = 1;
        check("b2b latency", cnt, 3);
        check("b2b ready in rsp", cmd_ready, 1);
        PREADY = 1'b0;
      end else begin
        check("b2b busy ready", cmd_ready, 0);
        PREADY = PENABLE;
        PSLVERR = 1'b0;
        @(negedge PCLK);
        cnt++;
      end
    end
    check("b2b first rsp", got, 1);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("b2b second setup", {PSELx, PENABLE, PWRITE, PADDR},
          {1'b1, 1'b0, 1'b0, 32'hB0});
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      PREADY = PENABLE;
      PRDATA = 32'h0B0B_0B0B;
      @(negedge PCLK);
      if (rsp_valid) got = 1;
    end
    check("b2b second rsp", {got[0], rsp_rdata}, {1'b1, 32'h0B0B_0B0B});
    PREADY = 1'b0;

    // reset during ACCESS aborts without response
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h77;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("rstmid in access", {PSELx, PENABLE}, 2'b11);
    PRESET = 1'b1; PREADY = 1'b1; PSLVERR = 1'b1;
    @(negedge PCLK);
    check("rstmid ctl", {PSELx, PENABLE, rsp_valid, rsp_err}, 0);
    check("rstmid addr", PADDR, 0);
    PRESET = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    @(negedge PCLK);
    check("rstmid release", {cmd_ready, rsp_valid}, 2'b10);

    // random traffic against a transaction timeline model
    busy = 0; rel = 0; acc = 1; tto = 0; twr = 0; terr = 0;
    trd = '0; la = '0; ld = '0; lw = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst_i = (c == 0) || ($urandom_range(0, 199) == 0);
      cv    = $urandom_range(0, 1) != 0;
      PRESET    = rst_i;
      cmd_valid = cv;
      cmd_write = $urandom_range(0, 1) != 0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      PREADY    = $urandom_range(0, 1) != 0;
      PSLVERR   = $urandom_range(0, 1) != 0;
      PRDATA    = $urandom;
      if (busy && rel >= 2) begin
        PREADY = !tto && (rel == 1 + acc);
        if (PREADY) begin
          PSLVERR = terr;
          PRDATA  = trd;
        end
      end
      e_rv = 0; e_err = 0; e_to = 0; e_rd = '0;
      if (rst_i) begin
        busy = 0; la = '0; ld = '0; lw = 1'b0;
        e_psel = 0; e_pen = 0; e_rdy = 1;
      end else if (!busy) begin
        if (cv) begin
          busy = 1; rel = 1;
          twr = cmd_write; lw = cmd_write;
          la = cmd_addr; ld = cmd_wdata;
          w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20)
                                          : $urandom_range(0, 2);
          tto  = TO_EN && (w >= TO);
          acc  = tto ? TO : w + 1;
          terr = $urandom_range(0, 1) != 0;
          trd  = $urandom;
          e_psel = 1; e_pen = 0; e_rdy = 0;
        end else begin
          e_psel = 0; e_pen = 0; e_rdy = 1;
        end
      end else if (rel < 1 + acc) begin
        rel++;
        e_psel = 1; e_pen = 1; e_rdy = 0;
      end else begin
        busy = 0;
        e_psel = 0; e_pen = 0; e_rdy = 1;
        e_rv = 1; e_to = tto; e_err = tto | terr;
        e_rd = (tto || twr) ? 32'h0 : trd;
      end
      @(negedge PCLK);
      check($sformatf("rnd%0d ctl", c),
            {cmd_ready, PSELx, PENABLE, rsp_valid, rsp_err, rsp_timeout},
            {e_rdy, e_psel, e_pen, e_rv, e_err, e_to});
      check($sformatf("rnd%0d bus", c), {PWRITE, PADDR, PWDATA},
            {lw, la, ld});
      check($sformatf("rnd%0d rdata", c), rsp_rdata, e_rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
